jogador_automatico: RTL and testbench
=====================================

Name: jogador_automatico

Overview:
- Automatic player for jogo_desafio_memoria; sits on the opposite side of the game's leds/botoes interface.
- Watches the LED sequence the game displays and stores it in a small buffer. When the game waits for plays, replays that sequence as timed button presses.
- Used on the board in self-play mode and by benches as a reusable stimulus source instead of hand-written press tasks.

Parameters:
- MAX_JOGADAS, 16, capacity of the sequence buffer (power of 2).
- PRESS_CICLOS, 2, clock cycles each button is held high (≥1).
- GAP_CICLOS, 2, clock cycles botoes is held at 0 between presses (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- habilitar  in  1  start pulse; acted on only in OCIOSO.
- erro_forcado  in  1  sampled at the start of each replay; if 1, the last press of that replay is corrupted.
- leds  in  4  game LED output, one-hot or 0.
- aguardando  in  1  high while the game expects plays.
- ganhou  in  1  game win flag.
- perdeu  in  1  game loss flag.
- botoes  out  4  button drive into the game.
- ocupado  out  1  high in every state except OCIOSO and FIM.
- concluido  out  1  high in FIM.
- venceu  out  1  ganhou latched on entry to FIM.
- estouro  out  1  sticky; a displayed item was dropped because the buffer was full.
- erro_padrao  out  1  sticky; a non-one-hot, nonzero leds value was seen.
- db_estado  out  3  current state code.
- db_qtd  out  clog2(MAX_JOGADAS)+1  items captured in the current round.

Behaviour:
- Reset (async, reset=0): state OCIOSO. botoes, concluido, venceu, estouro, erro_padrao and db_qtd all 0. Buffer contents are don't-care.
- Input registering: leds, aguardando, ganhou and perdeu are registered once. Edge detection uses the registered value and its previous-cycle copy.
- OCIOSO → OBSERVA on habilitar=1. On that transition, clear qtd, estouro, erro_padrao and venceu.
- OBSERVA:
  - On a registered leds edge from 0 to nonzero:
    - One-hot value and qtd<MAX_JOGADAS: write it to buf[qtd], then qtd+1.
    - One-hot value and qtd==MAX_JOGADAS: drop it and set estouro.
    - Non-one-hot value: drop it and set erro_padrao.
  - On a rising edge of registered aguardando:
    - qtd>0: latch erro_forcado, idx=0, go to PRESSIONA.
    - qtd==0: stay in OBSERVA.
- PRESSIONA:
  - botoes=buf[idx] for exactly PRESS_CICLOS cycles.
  - If this is the last press (idx==qtd-1) and the latched erro_forcado=1, drive (~buf[idx])&4'hF instead.
  - Then go to SOLTA.
- SOLTA:
  - botoes=0 for GAP_CICLOS cycles.
  - Then, if idx<qtd-1: idx+1 and back to PRESSIONA.
  - Else: qtd=0 and back to OBSERVA. The next round's display is re-captured from index 0.
- Latency: if aguardando is high at the input on edge t, botoes shows buf[0] from edge t+2 (one register plus one FSM cycle).
- Game-over handling:
  - Registered ganhou or perdeu =1 in OBSERVA, PRESSIONA or SOLTA → FIM on the next edge.
  - botoes=0 from that edge; an in-progress press is truncated.
  - venceu = registered ganhou at entry; ganhou takes priority if both are high.
- FIM: concluido=1. habilitar=1 → OBSERVA with the same clears as from OCIOSO, so two games can run back-to-back without reset.
- Ignored inputs:
  - habilitar in OBSERVA, PRESSIONA or SOLTA.
  - leds edges during PRESSIONA and SOLTA. The game echoes presses on leds, and these are not captured.
- Arithmetic: idx and qtd are unsigned. qtd saturates at MAX_JOGADAS and never wraps.
- Reset asserted mid-press: botoes goes to 0 asynchronously.

Decomposition:
- Package jogador_pkg holds:
  - state codes: OCIOSO=3'd0, OBSERVA=3'd1, PRESSIONA=3'd2, SOLTA=3'd3, FIM=3'd4;
  - a one-hot check function.
- Natural sub-module: jogador_buffer, a MAX_JOGADAS×4 register file with synchronous write and asynchronous read.
- The FSM and timing counters stay in the top module.

Test Plan:
- Reset then habilitar. Display 4'b0001, then aguardando=1 → botoes=0001 for 2 cycles, then 0 for 2 cycles. Back in OBSERVA with db_qtd=0.
- Round of 3 displayed as 0010, 0100, 1000 → presses 0010, 0100, 1000 in order. Each press lasts 2 cycles, with 2-cycle gaps.
- erro_forcado=1 with 1-item display 0001 → press 1110. Game drives perdeu=1 → concluido=1 and venceu=0 within 2 edges.
- perdeu asserted mid-press of a 3-item replay → botoes=0 on the next registered edge and state FIM. Then habilitar → OBSERVA without reset, and a 0001 display replays correctly.
- MAX_JOGADAS=4 with 5 displayed items → estouro=1, db_qtd=4, exactly 4 presses. Display 0011 → erro_padrao=1 and db_qtd unchanged.
- Full integration with jogo_desafio_memoria at configuracao=00 → ganhou=1 and venceu=1, with no manual button stimulus.

Source files
------------

// File: rtl/jogador_pkg.sv
// jogador_pkg: state codes and the one-hot helper shared by the automatic player
package jogador_pkg;
  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    OBSERVA   = 3'd1,
    PRESSIONA = 3'd2,
    SOLTA     = 3'd3,
    FIM       = 3'd4
  } estado_t;
  function automatic logic one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/jogador_buffer.sv
// jogador_buffer: DEPTH x 4 register file, synchronous write, asynchronous read
// ports: clock; we/waddr/wdata write port; raddr -> rdata combinational read
module jogador_buffer import jogador_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rdata
);
  logic [3:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/jogador_automatico.sv
// jogador_automatico: watches the game's LED sequence and replays it as timed button presses
// ports: clock, reset (async active-low), habilitar, erro_forcado, leds, aguardando, ganhou, perdeu in;
//        botoes, ocupado, concluido, venceu, estouro, erro_padrao, db_estado, db_qtd out
module jogador_automatico import jogador_pkg::*; #(
  parameter int MAX_JOGADAS  = 16,
  parameter int PRESS_CICLOS = 2,
  parameter int GAP_CICLOS   = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          habilitar,
  input  logic                          erro_forcado,
  input  logic [3:0]                    leds,
  input  logic                          aguardando,
  input  logic                          ganhou,
  input  logic                          perdeu,
  output logic [3:0]                    botoes,
  output logic                          ocupado,
  output logic                          concluido,
  output logic                          venceu,
  output logic                          estouro,
  output logic                          erro_padrao,
  output logic [2:0]                    db_estado,
  output logic [$clog2(MAX_JOGADAS):0]  db_qtd
);
  localparam int AW = $clog2(MAX_JOGADAS);
  localparam int QW = AW + 1;
  localparam int CW = $clog2(PRESS_CICLOS + GAP_CICLOS + 1);
  estado_t estado, prox;
  logic [3:0] leds_r, leds_p, rd, botoes_d;
  logic agu_r, agu_p, gan_r, per_r, err_l;
  logic [QW-1:0] qtd;
  logic [AW-1:0] idx;
  logic [CW-1:0] cnt;
  logic ev_leds, ev_agu, fim_go, ultimo, fim_press, fim_gap, cheio, wr, inicia;
  assign ev_leds   = (leds_p == 4'd0) && (leds_r != 4'd0);
  assign ev_agu    = agu_r && !agu_p;
  assign fim_go    = (gan_r || per_r) && (estado inside {OBSERVA, PRESSIONA, SOLTA});
  assign ultimo    = {1'b0, idx} == qtd - QW'(1);
  assign fim_press = cnt == CW'(PRESS_CICLOS - 1);
  assign fim_gap   = cnt == CW'(GAP_CICLOS - 1);
  assign cheio     = qtd == QW'(MAX_JOGADAS);
  assign wr        = (estado == OBSERVA) && !fim_go && ev_leds && one_hot(leds_r) && !cheio;
  assign inicia    = (estado == OCIOSO || estado == FIM) && habilitar;
  jogador_buffer #(.DEPTH(MAX_JOGADAS)) u_buf (
    .clock (clock),
    .we    (wr),
    .waddr (qtd[AW-1:0]),
    .wdata (leds_r),
    .raddr (idx),
    .rdata (rd)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else estado <= prox;
  end
  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO, FIM: prox = habilitar ? OBSERVA : estado;
      OBSERVA:     prox = (ev_agu && qtd != '0) ? PRESSIONA : OBSERVA;
      PRESSIONA:   prox = fim_press ? SOLTA : PRESSIONA;
      SOLTA:       prox = !fim_gap ? SOLTA : ultimo ? OBSERVA : PRESSIONA;
      default:     prox = OCIOSO;
    endcase
    if (fim_go) prox = FIM;
  end
  // botoes is registered from the current state, so it trails the FSM by one cycle;
  // game over forces 0 on the same edge the FSM enters FIM, truncating a press
  always_comb begin
    botoes_d  = (estado == PRESSIONA && !fim_go) ? ((ultimo && err_l) ? ~rd : rd) : 4'd0;
    ocupado   = estado inside {OBSERVA, PRESSIONA, SOLTA};
    concluido = estado == FIM;
    db_estado = estado;
    db_qtd    = qtd;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      leds_r      <= '0;
      leds_p      <= '0;
      agu_r       <= 1'b0;
      agu_p       <= 1'b0;
      gan_r       <= 1'b0;
      per_r       <= 1'b0;
      qtd         <= '0;
      idx         <= '0;
      cnt         <= '0;
      err_l       <= 1'b0;
      estouro     <= 1'b0;
      erro_padrao <= 1'b0;
      venceu      <= 1'b0;
      botoes      <= 4'd0;
    end else begin
      leds_r <= leds;
      leds_p <= leds_r;
      agu_r  <= aguardando;
      agu_p  <= agu_r;
      gan_r  <= ganhou;
      per_r  <= perdeu;
      botoes <= botoes_d;
      cnt    <= (prox != estado) ? '0 : cnt + CW'(1);
      if (inicia) begin
        qtd         <= '0;
        estouro     <= 1'b0;
        erro_padrao <= 1'b0;
        venceu      <= 1'b0;
      end
      if (estado == OBSERVA && !fim_go && ev_leds) begin
        if (!one_hot(leds_r)) erro_padrao <= 1'b1;
        else if (cheio) estouro <= 1'b1;
        else qtd <= qtd + QW'(1);
      end
      if (estado == OBSERVA && prox == PRESSIONA) begin
        idx   <= '0;
        err_l <= erro_forcado;
      end
      if (estado == SOLTA && prox == PRESSIONA) idx <= idx + AW'(1);
      if (estado == SOLTA && prox == OBSERVA) qtd <= '0;
      if (prox == FIM && estado != FIM) venceu <= gan_r;
    end
  end
endmodule

// File: tb/tb_jogador_automatico.sv
// tb_jogador_automatico: randomized self-checking bench with a queue-based model of the player
module tb_jogador_automatico;
  localparam int MAXJ = 4;
  localparam int P = 2;
  localparam int G = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic habilitar = 1'b0, erro_forcado = 1'b0, aguardando = 1'b0, ganhou = 1'b0, perdeu = 1'b0;
  logic [3:0] leds = 4'd0;
  logic [3:0] botoes;
  logic ocupado, concluido, venceu, estouro, erro_padrao;
  logic [2:0] db_estado;
  logic [2:0] db_qtd;
  int checks = 0;
  int fails = 0;
  logic [3:0] exp_buf[$];
  logic exp_est = 1'b0;
  logic exp_err = 1'b0;
  jogador_automatico #(.MAX_JOGADAS(MAXJ), .PRESS_CICLOS(P), .GAP_CICLOS(G)) dut (
    .clock        (clock),
    .reset        (reset),
    .habilitar    (habilitar),
    .erro_forcado (erro_forcado),
    .leds         (leds),
    .aguardando   (aguardando),
    .ganhou       (ganhou),
    .perdeu       (perdeu),
    .botoes       (botoes),
    .ocupado      (ocupado),
    .concluido    (concluido),
    .venceu       (venceu),
    .estouro      (estouro),
    .erro_padrao  (erro_padrao),
    .db_estado    (db_estado),
    .db_qtd       (db_qtd)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string name, input int got, input int want);
  endtask
  task automatic pulse_hab();
    habilitar = 1'b1;
    tick();
    habilitar = 1'b0;
    exp_buf.delete();
    exp_est = 1'b0;
    exp_err = 1'b0;
  endtask
  task automatic show(input logic [3:0] v);
    leds = v;
    repeat ($urandom_range(1, 3)) tick();
    leds = 4'd0;
    repeat ($urandom_range(1, 3)) tick();
    if ($countones(v) == 1) begin
      if (exp_buf.size() < MAXJ) exp_buf.push_back(v);
      else exp_est = 1'b1;
    end else if (v != 4'd0) exp_err = 1'b1;
  endtask
  task automatic check_flags(input string tag);
    checks++;
    if (db_qtd !== 3'(exp_buf.size())) begin
      fails++;
      $display("FAIL %s db_qtd got %0d want %0d", tag, db_qtd, exp_buf.size());
    end
    checks++;
    if (estouro !== exp_est || erro_padrao !== exp_err) begin
      fails++;
      $display("FAIL %s flags estouro/erro_padrao got %b%b want %b%b", tag, estouro, erro_padrao, exp_est, exp_err);
    end
  endtask
  task automatic replay(input string tag, input logic err);
    int n = exp_buf.size();
    int len = 2 + n * (P + G) + 1;
    logic [3:0] want;
    erro_forcado = err;
    aguardando = 1'b1;
    for (int j = 0; j < len; j++) begin
      tick();
      want = 4'd0;
      if (j >= 2 && j < 2 + n * (P + G) && (j - 2) % (P + G) < P) begin
        want = exp_buf[(j - 2) / (P + G)];
        if (err && (j - 2) / (P + G) == n - 1) want = ~want;
      end
      checks++;
      if (botoes !== want) begin
        fails++;
        $display("FAIL %s botoes cycle %0d got %b want %b", tag, j, botoes, want);
      end
      leds = botoes;
    end
    leds = 4'd0;
    checks++;
    if (db_estado !== 3'd1 || db_qtd !== 3'd0) begin
      fails++;
      $display("FAIL %s end_of_replay estado/qtd got %0d/%0d want 1/0", tag, db_estado, db_qtd);
    end
    exp_buf.delete();
    aguardando = 1'b0;
    erro_forcado = 1'b0;
    repeat (3) tick();
  endtask
  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) tick();
    checks++;
    if ({botoes, ocupado, concluido, venceu, estouro, erro_padrao, db_estado, db_qtd} !== 15'd0) begin
      fails++;
      $display("FAIL reset outputs got %b %b%b%b%b%b %0d %0d want all 0", botoes, ocupado, concluido, venceu, estouro, erro_padrao, db_estado, db_qtd);
    end
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (db_estado !== 3'd0) begin
      fails++;
      $display("FAIL idle_without_hab estado got %0d want 0", db_estado);
    end
  endtask
  task automatic test_single();
    pulse_hab();
    checks++;
    if (db_estado !== 3'd1 || ocupado !== 1'b1) begin
      fails++;
      $display("FAIL habilitar estado/ocupado got %0d/%b want 1/1", db_estado, ocupado);
    end
    show(4'b0001);
    check_flags("single");
    replay("single", 1'b0);
  endtask
  task automatic test_three();
    show(4'b0010);
    show(4'b0100);
    show(4'b1000);
    check_flags("three");
    replay("three", 1'b0);
  endtask
  task automatic test_random_rounds();
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        logic [3:0] v;
        v = 4'd1 << $urandom_range(0, 3);
        if ($urandom_range(0, 9) == 0) v = 4'($urandom_range(1, 15));
        show(v);
      end
      check_flags("random");
      if (exp_buf.size() > 0) replay("random", 1'($urandom_range(0, 1)));
    end
  endtask
  task automatic test_erro_perdeu();
    pulse_hab();
    show(4'b0001);
    replay("forced_error", 1'b1);
    perdeu = 1'b1;
    repeat (2) tick();
    checks++;
    if (concluido !== 1'b1 || venceu !== 1'b0 || db_estado !== 3'd4 || ocupado !== 1'b0) begin
      fails++;
      $display("FAIL perdeu_fim concluido/venceu/estado/ocupado got %b/%b/%0d/%b want 1/0/4/0", concluido, venceu, db_estado, ocupado);
    end
    perdeu = 1'b0;
    repeat (2) tick();
  endtask
  task automatic test_truncate();
    pulse_hab();
    show(4'b0100);
    show(4'b0010);
    show(4'b1000);
    aguardando = 1'b1;
    repeat (2) tick();
    perdeu = 1'b1;
    tick();
    checks++;
    if (botoes !== 4'b0100) begin
      fails++;
      $display("FAIL truncate_first botoes got %b want 0100", botoes);
    end
    tick();
    checks++;
    if (botoes !== 4'd0 || db_estado !== 3'd4 || concluido !== 1'b1) begin
      fails++;
      $display("FAIL truncate botoes/estado/concluido got %b/%0d/%b want 0000/4/1", botoes, db_estado, concluido);
    end
    perdeu = 1'b0;
    aguardando = 1'b0;
    repeat (3) tick();
    pulse_hab();
    checks++;
    if (db_estado !== 3'd1 || concluido !== 1'b0 || db_qtd !== 3'd0) begin
      fails++;
      $display("FAIL rehab estado/concluido/qtd got %0d/%b/%0d want 1/0/0", db_estado, concluido, db_qtd);
    end
    show(4'b0001);
    replay("after_rehab", 1'b0);
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 5; i++) show(4'd1 << (i % 4));
    check_flags("overflow");
    show(4'b0011);
    check_flags("bad_pattern");
    replay("overflow", 1'b0);
  endtask
  task automatic test_win();
    show(4'b1000);
    ganhou = 1'b1;
    perdeu = 1'b1;
    repeat (2) tick();
    checks++;
    if (concluido !== 1'b1 || venceu !== 1'b1) begin
      fails++;
      $display("FAIL win concluido/venceu got %b/%b want 1/1", concluido, venceu);
    end
    ganhou = 1'b0;
    perdeu = 1'b0;
    repeat (2) tick();
    pulse_hab();
    check_flags("win_clears");
  endtask
  task automatic test_async_reset();
    show(4'b0010);
    aguardando = 1'b1;
    repeat (3) tick();
    checks++;
    if (botoes !== 4'b0010) begin
      fails++;
      $display("FAIL pre_reset botoes got %b want 0010", botoes);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (botoes !== 4'd0 || db_estado !== 3'd0) begin
      fails++;
      $display("FAIL async_reset botoes/estado got %b/%0d want 0000/0", botoes, db_estado);
    end
    aguardando = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask
  initial begin
    test_reset();
    test_single();
    test_three();
    test_random_rounds();
    test_erro_perdeu();
    test_truncate();
    test_overflow();
    test_win();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
